uart_reg_master: RTL and testbench

Command engine between the UART byte FIFOs and the `uart_regs` register bus. It pops command bytes from the RX FIFO and drives single-cycle `rd_req`/`wr_req` transactions into `uart_regs`. Read data, ACK and NAK bytes are pushed into the TX FIFO. It is the bus initiator for the host PC link.

---
 rtl/uart_pkg.sv | 49 ++++
 rtl/uart_reg_master.sv | 118 +++++++++++
 tb/tb_uart_reg_master.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART register-bus command engine: register map,
// command byte layout, response codes and master FSM encodings.
package uart_pkg;

   // uart_regs register offsets
   localparam logic [2:0] UART_CR_OFFSET    = 3'd0;
   localparam logic [2:0] UART_SR_OFFSET    = 3'd1;
   localparam logic [2:0] UART_DINL_OFFSET  = 3'd2;
   localparam logic [2:0] UART_DINH_OFFSET  = 3'd3;
   localparam logic [2:0] UART_DOUTL_OFFSET = 3'd4;
   localparam logic [2:0] UART_DOUTH_OFFSET = 3'd5;
   localparam logic [2:0] UART_BAUDL_OFFSET = 3'd6;
   localparam logic [2:0] UART_BAUDH_OFFSET = 3'd7;

   // Command byte fields
   localparam int CMD_WR_BIT   = 7;
   localparam int CMD_RSV_MSB  = 6;
   localparam int CMD_RSV_LSB  = 3;
   localparam int CMD_ADDR_MSB = 2;
   localparam int CMD_ADDR_LSB = 0;

   localparam logic [7:0] UART_ACK = 8'h06;
   localparam logic [7:0] UART_NAK = 8'h15;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_DECODE    = 3'd1;
   localparam logic [2:0] ST_WAIT_DATA = 3'd2;
   localparam logic [2:0] ST_WRITE     = 3'd3;
   localparam logic [2:0] ST_READ      = 3'd4;
   localparam logic [2:0] ST_RCAP      = 3'd5;
   localparam logic [2:0] ST_ERR       = 3'd6;
   localparam logic [2:0] ST_TX        = 3'd7;

   typedef enum logic [2:0] {
      MS_IDLE      = ST_IDLE,
      MS_DECODE    = ST_DECODE,
      MS_WAIT_DATA = ST_WAIT_DATA,
      MS_WRITE     = ST_WRITE,
      MS_READ      = ST_READ,
      MS_RCAP      = ST_RCAP,
      MS_ERR       = ST_ERR,
      MS_TX        = ST_TX
   } uart_master_state_t;

   function automatic logic cmd_reserved_clear(input logic [7:0] cmd);
      return cmd[CMD_RSV_MSB:CMD_RSV_LSB] == 4'd0;
   endfunction

endpackage

// File: rtl/uart_reg_master.sv
// Host-link bus initiator: pops command bytes from the RX FIFO, issues single
// read/write strobes to uart_regs and pushes read data, ACK or NAK to the TX FIFO.
module uart_reg_master
   import uart_pkg::*;
#(
   parameter int TIMEOUT = 100000,
   parameter bit ACK_EN  = 1'b1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_rx_data,
   input  logic       i_rx_fifo_e,
   output logic       o_rx_rd,
   output logic [7:0] o_tx_data,
   output logic       o_tx_wr,
   input  logic       i_tx_fifo_f,
   output logic [2:0] o_rwaddr,
   output logic [7:0] o_write_data,
   output logic       o_wr_req,
   output logic       o_rd_req,
   input  logic [7:0] i_read_data,
   output logic       o_busy,
   output logic [7:0] o_err_cnt
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   uart_master_state_t state, state_nxt;
   logic [7:0]    cmd;
   logic [7:0]    resp;
   logic [TW-1:0] timer;
   logic          rx_pop;
   logic          tx_push;

   // FIFO handshakes are decoded from the state register so the pop/push lands on
   // the same edge that latches the byte; reset masks them so an abort never pops or pushes.
   assign rx_pop  = !i_rst && !i_rx_fifo_e && (state == MS_IDLE || state == MS_WAIT_DATA);
   assign tx_push = !i_rst && !i_tx_fifo_f && (state == MS_TX);

   assign o_rx_rd   = rx_pop;
   assign o_tx_wr   = tx_push;
   assign o_tx_data = resp;

   always_comb begin
      // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
      state_nxt = state;
      case (state)
         MS_IDLE:      if (rx_pop) state_nxt = MS_DECODE;
         MS_DECODE: begin
            if (!cmd_reserved_clear(cmd))  state_nxt = MS_ERR;
            else if (cmd[CMD_WR_BIT])      state_nxt = MS_WAIT_DATA;
            else                           state_nxt = MS_READ;
         end
         MS_WAIT_DATA: begin
            if (rx_pop)                    state_nxt = MS_WRITE;
            else if (timer == TIMER_LAST)  state_nxt = MS_ERR;
         end
         MS_WRITE:     state_nxt = ACK_EN ? MS_TX : MS_IDLE;
         MS_READ:      state_nxt = MS_RCAP;
         MS_RCAP:      state_nxt = MS_TX;
         MS_ERR:       state_nxt = MS_TX;
         MS_TX:        if (tx_push) state_nxt = MS_IDLE;
         default:      state_nxt = MS_IDLE;
      endcase
   end

   // NOTE: all state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= MS_IDLE;
         cmd          <= '0;
         resp         <= '0;
         timer        <= '0;
         o_rwaddr     <= '0;
         o_write_data <= '0;
         o_wr_req     <= 1'b0;
         o_rd_req     <= 1'b0;
         o_busy       <= 1'b0;
         o_err_cnt    <= '0;
      end else begin
         state    <= state_nxt;
         o_busy   <= (state_nxt != MS_IDLE);
         o_rd_req <= (state_nxt == MS_READ);
         o_wr_req <= (state_nxt == MS_WRITE);

         case (state)
            MS_IDLE: begin
               if (rx_pop) cmd <= i_rx_data;
            end
            MS_DECODE: begin
               timer <= '0;
               if (state_nxt == MS_READ) o_rwaddr <= cmd[CMD_ADDR_MSB:CMD_ADDR_LSB];
            end
            MS_WAIT_DATA: begin
               if (rx_pop) begin
                  o_write_data <= i_rx_data;
                  o_rwaddr     <= cmd[CMD_ADDR_MSB:CMD_ADDR_LSB];
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            MS_WRITE: begin
               if (ACK_EN) resp <= UART_ACK;
            end
            MS_RCAP: begin
               resp <= i_read_data;
            end
            MS_ERR: begin
               resp <= UART_NAK;
               if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_reg_master.sv
// Directed bench for uart_reg_master: vector table of single transactions plus
// hand sequences for timeout, TX back-pressure and mid-transaction reset.
module tb_uart_reg_master;
   import uart_pkg::*;

   localparam int TIMEOUT = 16;

   logic       clk = 1'b0;
   logic       i_rst;
   logic [7:0] i_rx_data;
   logic       i_rx_fifo_e;
   logic       o_rx_rd;
   logic [7:0] o_tx_data;
   logic       o_tx_wr;
   logic       i_tx_fifo_f;
   logic [2:0] o_rwaddr;
   logic [7:0] o_write_data;
   logic       o_wr_req;
   logic       o_rd_req;
   logic [7:0] i_read_data;
   logic       o_busy;
   logic [7:0] o_err_cnt;

   always #5 clk = ~clk;

   uart_reg_master #(.TIMEOUT(TIMEOUT), .ACK_EN(1'b1)) dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_rx_data   (i_rx_data),
      .i_rx_fifo_e (i_rx_fifo_e),
      .o_rx_rd     (o_rx_rd),
      .o_tx_data   (o_tx_data),
      .o_tx_wr     (o_tx_wr),
      .i_tx_fifo_f (i_tx_fifo_f),
      .o_rwaddr    (o_rwaddr),
      .o_write_data(o_write_data),
      .o_wr_req    (o_wr_req),
      .o_rd_req    (o_rd_req),
      .i_read_data (i_read_data),
      .o_busy      (o_busy),
      .o_err_cnt   (o_err_cnt)
   );

   // RX FIFO model, first-word-fall-through
   logic [7:0] rx_mem [0:63];
   int rx_wr = 0;
   int rx_rd = 0;
   assign i_rx_fifo_e = (rx_rd == rx_wr);
   assign i_rx_data   = rx_mem[rx_rd[5:0]];

   always @(posedge clk) if (o_rx_rd) rx_rd <= rx_rd + 1;

   // uart_regs model: read data valid the cycle after o_rd_req
   logic [7:0] regs [0:7];
   always @(posedge clk) begin
      if (i_rst) begin
         for (int k = 0; k < 8; k++) regs[k] <= 8'(k * 17);
         regs[4]     <= 8'h5C;
         i_read_data <= 8'h00;
      end else begin
         if (o_wr_req) regs[o_rwaddr] <= o_write_data;
         if (o_rd_req) i_read_data <= regs[o_rwaddr];
      end
   end

   // Event logs stamped with the cycle that ends at the sampling edge
   int         cyc = 0;
   logic [7:0] tx_q [$];
   int         tx_c [$];
   int         pop_c [$];
   logic [10:0] wr_q [$];
   int         wr_c [$];
   logic [2:0] rd_a [$];
   int         rd_c [$];
   int         both_cnt = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (o_tx_wr) begin tx_q.push_back(o_tx_data); tx_c.push_back(cyc); end
      if (o_rx_rd) pop_c.push_back(cyc);
      if (o_wr_req) begin wr_q.push_back({o_rwaddr, o_write_data}); wr_c.push_back(cyc); end
      if (o_rd_req) begin rd_a.push_back(o_rwaddr); rd_c.push_back(cyc); end
      if (o_rd_req && o_wr_req) both_cnt = both_cnt + 1;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic clear_logs();
      tx_q.delete(); tx_c.delete(); pop_c.delete();
      wr_q.delete(); wr_c.delete(); rd_a.delete(); rd_c.delete();
   endtask

   task automatic push_rx(input logic [7:0] b);
      rx_mem[rx_wr[5:0]] = b;
      rx_wr = rx_wr + 1;
   endtask

   task automatic wait_tx(input int n, input int budget, input string name);
      int k;
      k = 0;
      while (tx_q.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (tx_q.size() < n) begin
         n_checks++;
         $display("FAIL %s: TX push not seen, got %0d bytes, expected %0d", name, tx_q.size(), n);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return {o_rx_rd, o_tx_wr, o_tx_data, o_rwaddr, o_write_data,
              o_wr_req, o_rd_req, o_busy, o_err_cnt};
   endfunction

   typedef struct {
      logic [7:0] cmd;
      logic [7:0] data;
      bit         has_data;
      logic [7:0] exp_tx;
      int         exp_lat;   // cycles from command pop to TX push
      bit         exp_wr;
      bit         exp_rd;
      logic [2:0] exp_addr;  // o_rwaddr after the transaction
      logic [7:0] exp_err;
   } vec_t;

   vec_t vecs [10];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{{5'b10000, UART_CR_OFFSET}, 8'hAA, 1'b1, UART_ACK, 4, 1'b1, 1'b0, UART_CR_OFFSET, 8'd0};
      vecs[1] = '{{5'b00000, UART_CR_OFFSET}, 8'h00, 1'b0, 8'hAA,    4, 1'b0, 1'b1, UART_CR_OFFSET, 8'd0};
      vecs[2] = '{{5'b00000, UART_DOUTL_OFFSET}, 8'h00, 1'b0, 8'h5C, 4, 1'b0, 1'b1, UART_DOUTL_OFFSET, 8'd0};
      vecs[3] = '{8'h48, 8'h00, 1'b0, UART_NAK, 3, 1'b0, 1'b0, 3'd4, 8'd1};
      vecs[4] = '{8'h87, 8'h3C, 1'b1, UART_ACK, 4, 1'b1, 1'b0, 3'd7, 8'd1};
      vecs[5] = '{8'h07, 8'h00, 1'b0, 8'h3C,    4, 1'b0, 1'b1, 3'd7, 8'd1};
      vecs[6] = '{8'hF8, 8'h00, 1'b0, UART_NAK, 3, 1'b0, 1'b0, 3'd7, 8'd2};
      vecs[7] = '{8'h83, 8'h00, 1'b1, UART_ACK, 4, 1'b1, 1'b0, 3'd3, 8'd2};
      vecs[8] = '{8'h03, 8'h00, 1'b0, 8'h00,    4, 1'b0, 1'b1, 3'd3, 8'd2};
      vecs[9] = '{8'h01, 8'h00, 1'b0, 8'h11,    4, 1'b0, 1'b1, 3'd1, 8'd2};

      i_rst       = 1'b1;
      i_tx_fifo_f = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", all_outs(), 32'h0);
      i_rst = 1'b0;
      @(negedge clk);
      check("idle_after_reset", all_outs(), 32'h0);

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         clear_logs();
         push_rx(vecs[i].cmd);
         if (vecs[i].has_data) push_rx(vecs[i].data);
         wait_tx(1, 40, $sformatf("v%0d_tx_wait", i));
         if (tx_q.size() > 0 && pop_c.size() > 0) begin
            check($sformatf("v%0d_tx_byte", i), 32'(tx_q[0]), 32'(vecs[i].exp_tx));
            check($sformatf("v%0d_tx_lat", i), 32'(tx_c[0] - pop_c[0]), 32'(vecs[i].exp_lat));
         end
         check($sformatf("v%0d_pops", i), 32'(pop_c.size()), vecs[i].has_data ? 32'd2 : 32'd1);
         check($sformatf("v%0d_wr_cnt", i), 32'(wr_q.size()), 32'(vecs[i].exp_wr));
         check($sformatf("v%0d_rd_cnt", i), 32'(rd_a.size()), 32'(vecs[i].exp_rd));
         if (vecs[i].exp_wr && wr_q.size() > 0 && pop_c.size() > 1) begin
            check($sformatf("v%0d_wr_bus", i), 32'(wr_q[0]), 32'({vecs[i].exp_addr, vecs[i].data}));
            check($sformatf("v%0d_data_pop_cyc", i), 32'(pop_c[1] - pop_c[0]), 32'd2);
            check($sformatf("v%0d_wr_cyc", i), 32'(wr_c[0] - pop_c[0]), 32'd3);
         end
         if (vecs[i].exp_rd && rd_a.size() > 0 && pop_c.size() > 0) begin
            check($sformatf("v%0d_rd_addr", i), 32'(rd_a[0]), 32'(vecs[i].exp_addr));
            check($sformatf("v%0d_rd_cyc", i), 32'(rd_c[0] - pop_c[0]), 32'd2);
         end
         check($sformatf("v%0d_rwaddr", i), 32'(o_rwaddr), 32'(vecs[i].exp_addr));
         check($sformatf("v%0d_err_cnt", i), 32'(o_err_cnt), 32'(vecs[i].exp_err));
         check($sformatf("v%0d_busy", i), 32'(o_busy), 32'd0);
      end

      // Write with no data byte: 16 WAIT_DATA cycles, then ERR, then the NAK push
      @(negedge clk);
      clear_logs();
      push_rx(8'h81);
      wait_tx(1, 60, "timeout_wait");
      if (tx_q.size() > 0 && pop_c.size() > 0) begin
         check("timeout_nak", 32'(tx_q[0]), 32'(UART_NAK));
         check("timeout_lat", 32'(tx_c[0] - pop_c[0]), 32'd19);
      end
      check("timeout_pops", 32'(pop_c.size()), 32'd1);
      check("timeout_no_wr", 32'(wr_q.size()), 32'd0);
      check("timeout_err_cnt", 32'(o_err_cnt), 32'd3);

      @(negedge clk);
      clear_logs();
      push_rx(8'h02);
      wait_tx(1, 40, "late_byte_wait");
      if (tx_q.size() > 0) check("late_byte_tx", 32'(tx_q[0]), 32'h22);
      if (rd_a.size() > 0) check("late_byte_rd_addr", 32'(rd_a[0]), 32'd2);
      check("late_byte_rd_cnt", 32'(rd_a.size()), 32'd1);

      // TX full while the read response is pending; a second command waits in RX
      @(negedge clk);
      clear_logs();
      i_tx_fifo_f = 1'b1;
      push_rx({5'b00000, UART_DOUTL_OFFSET});
      push_rx({5'b00000, UART_CR_OFFSET});
      repeat (14) @(negedge clk);
      check("txfull_no_push", 32'(tx_q.size()), 32'd0);
      check("txfull_no_pop", 32'(pop_c.size()), 32'd1);
      check("txfull_busy", 32'(o_busy), 32'd1);
      begin
         int rel;
         rel = cyc;
         i_tx_fifo_f = 1'b0;
         wait_tx(2, 40, "txfull_release_wait");
         if (tx_q.size() > 1 && pop_c.size() > 1) begin
            check("txfull_first_byte", 32'(tx_q[0]), 32'h5C);
            check("txfull_push_cyc", 32'(tx_c[0]), 32'(rel));
            check("b2b_next_pop", 32'(pop_c[1] - tx_c[0]), 32'd1);
            check("b2b_second_byte", 32'(tx_q[1]), 32'hAA);
         end
      end

      // Reset while waiting for a write data byte
      @(negedge clk);
      clear_logs();
      push_rx({5'b10000, UART_DOUTH_OFFSET});
      repeat (4) @(negedge clk);
      check("rst_pre_busy", 32'(o_busy), 32'd1);
      i_rst = 1'b1;
      @(negedge clk);
      check("rst_mid_outputs", all_outs(), 32'h0);
      i_rst = 1'b0;
      @(negedge clk);
      check("rst_mid_no_wr", 32'(wr_q.size()), 32'd0);
      check("rst_mid_no_tx", 32'(tx_q.size()), 32'd0);

      clear_logs();
      push_rx({5'b10000, UART_DOUTH_OFFSET});
      push_rx(8'h77);
      wait_tx(1, 40, "post_rst_wait");
      if (tx_q.size() > 0) check("post_rst_ack", 32'(tx_q[0]), 32'(UART_ACK));
      if (wr_q.size() > 0) check("post_rst_wr_bus", 32'(wr_q[0]), 32'({UART_DOUTH_OFFSET, 8'h77}));
      check("post_rst_err_cnt", 32'(o_err_cnt), 32'd0);

      check("rd_wr_never_together", 32'(both_cnt), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
